clock_12h: RTL and testbench
============================

Name: clock_12h

Overview:
- BCD 12-hour time-of-day counter (hh:mm:ss + AM/PM).
- Sits directly downstream of the 1 kHz-to-1 Hz prescaler and advances one second per cycle in which its OneHertz-derived enable is high.
- Supports a synchronous time-load with a validity check.
- Drives hour/minute carry strobes for later alarm/display stages.

Parameters:
- RESET_HH, 8'h12, BCD hour value loaded on reset (legal 01..12).
- RESET_PM, 1'b0, AM/PM value loaded on reset (0 = AM).

Ports:
- clk  input  1  system clock (same 1 kHz domain as the prescaler)
- reset  input  1  asynchronous, active-low reset
- ena  input  1  one-second tick; one-cycle pulse from the prescaler OneHertz output
- load  input  1  load request; sampled every clk
- load_hh  input  8  BCD hour to load (01..12)
- load_mm  input  8  BCD minute to load (00..59)
- load_ss  input  8  BCD second to load (00..59)
- load_pm  input  1  AM/PM to load
- hh  output  8  BCD hours, registered
- mm  output  8  BCD minutes, registered
- ss  output  8  BCD seconds, registered
- pm  output  1  1 = PM, registered
- min_tick  output  1  one-cycle pulse on each ss 59->00 advance
- hour_tick  output  1  one-cycle pulse on each mm 59->00 advance
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset low, asynchronous):
  - hh = RESET_HH, mm = 8'h00, ss = 8'h00, pm = RESET_PM.
  - min_tick, hour_tick and load_err are all 0.
  - Reset release takes effect at the next clk edge; no ena is lost or invented.
- All outputs are registered.
- Latency: a new time value appears one clk after the edge that samples ena or load high.
- Second advance (ena=1, load=0):
  - ss increments in BCD: x9 -> (x+1)0; 59 -> 00.
  - ss 59->00: mm increments in BCD, and min_tick=1 on that same edge.
  - mm 59->00 together with ss 59->00: hh advances 12->01, 01->02 ... 09->10, 10->11, 11->12, and hour_tick=1.
  - hh 11->12 toggles pm. The 12->01 transition does not toggle pm.
  - The full rollover 11:59:59 PM -> 12:00:00 AM asserts min_tick and hour_tick and toggles pm, all in one cycle.
- ena=0 and load=0: every value holds; all pulses are 0.
- Load (load=1): load has priority over ena; the ena in that cycle is discarded, not deferred.
  - Valid load: each nibble <= 9, hh in 01..12, mm and ss in 00..59. The registers take load_* on the next edge. No ticks; load_err=0.
  - Invalid load: time holds and load_err=1 for one cycle.
  - A load held high for N cycles is re-evaluated every cycle.
- Pulse outputs are high for exactly one cycle per event. They never assert when ena=0, except load_err.
- Internal state never leaves the legal BCD ranges. No illegal-state recovery is required because the load check prevents entry.
- Reset asserted mid-load or mid-rollover overrides everything, asynchronously.

Decomposition:
- Shared package, clock_pkg: BCD constants BCD_00, BCD_01, BCD_09, BCD_11, BCD_12, BCD_59, and a function bcd_valid(value, max) that the load check uses.
- Sub-module bcd_mod60 (ss and mm instances):
  - Inputs: clk, reset, inc, ld, ld_val.
  - Outputs: q[7:0], wrap.
  - wrap is combinational: high when inc is asserted and q==59.
- Hour stepping, the pm toggle, the load validation and the tick registers stay in clock_12h.

Test Plan:
- Reset with defaults -> hh=12, mm=00, ss=00, pm=0 and all pulses 0, including reset asserted asynchronously between edges.
- 60 ena pulses from 12:00:00 AM -> ss steps 00..59 then 00, mm=01, min_tick exactly once, hour_tick never.
- Load 11:59:59 PM (pm=1), then one ena -> 12:00:00 AM, with min_tick=1, hour_tick=1 and pm=0 in the same cycle.
- Load 12:59:59 AM, then one ena -> 01:00:00 AM with pm unchanged. Load 11:59:59 AM, then one ena -> 12:00:00 PM.
- Load hh=8'h13, and separately mm=8'h5A -> load_err pulses one cycle each and the time is unchanged. Load and ena together with a valid value -> the loaded value appears exactly, with no extra second.
- ena pulsed every 1000 cycles with ena=0 in between -> outputs hold steady between ticks and each tick produces exactly one increment.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD constants and helpers for the 12-hour time-of-day counter.
package clock_pkg;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_09 = 8'h09;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_59 = 8'h59;

  // True when both nibbles are decimal digits and the value does not exceed max.
  // With legal digits, BCD ordering matches plain binary ordering.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

  // Two-digit BCD increment without range wrap; callers handle their own limits.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value[3:0] == BCD_09[3:0]) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous load; used for seconds and minutes.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       wrap
);

  // Carry out to the next stage on the increment that takes 59 back to 00.
  assign wrap = inc && (q == BCD_59);

  // Count register: load wins over increment, 59 rolls to 00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= BCD_00;
    end else if (ld) begin
      q <= ld_val;
    end else if (wrap) begin
      q <= BCD_00;
    end else if (inc) begin
      q <= bcd_inc(q);
    end
  end

endmodule

// File: rtl/clock_12h.sv
// BCD 12-hour time-of-day counter (hh:mm:ss + AM/PM) with checked time load
// and one-cycle minute/hour carry strobes.
module clock_12h
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_HH = 8'h12,
  parameter logic       RESET_PM = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       load_err
);

  logic sec_step;
  logic load_legal;
  logic load_ok;
  logic load_bad;
  logic ss_wrap;
  logic mm_wrap;

  // A load in the same cycle as a tick swallows the tick rather than deferring it.
  assign sec_step   = ena && !load;
  assign load_legal = bcd_valid(load_hh, BCD_12) && (load_hh != BCD_00) &&
                      bcd_valid(load_mm, BCD_59) && bcd_valid(load_ss, BCD_59);
  assign load_ok    = load && load_legal;
  assign load_bad   = load && !load_legal;

  bcd_mod60 u_sec (
    .clk    (clk),
    .reset  (reset),
    .inc    (sec_step),
    .ld     (load_ok),
    .ld_val (load_ss),
    .q      (ss),
    .wrap   (ss_wrap)
  );

  bcd_mod60 u_min (
    .clk    (clk),
    .reset  (reset),
    .inc    (ss_wrap),
    .ld     (load_ok),
    .ld_val (load_mm),
    .q      (mm),
    .wrap   (mm_wrap)
  );

  // Hour stepping 12->01->...->12; only the 11->12 step flips AM/PM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hh <= RESET_HH;
      pm <= RESET_PM;
    end else if (load_ok) begin
      hh <= load_hh;
      pm <= load_pm;
    end else if (mm_wrap) begin
      if (hh == BCD_12) begin
        hh <= BCD_01;
      end else begin
        hh <= bcd_inc(hh);
        if (hh == BCD_11) begin
          pm <= !pm;
        end
      end
    end
  end

  // Registered one-cycle event strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_tick  <= ss_wrap;
      hour_tick <= mm_wrap;
      load_err  <= load_bad;
    end
  end

endmodule

// File: tb/tb_clock_12h.sv
// Directed scoreboard bench for clock_12h; the reference keeps time as a
// 24-hour seconds count and converts to 12-hour BCD for comparison.
module tb_clock_12h;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       min_tick;
  logic       hour_tick;
  logic       load_err;

  int vectors     = 0;
  int miscompares = 0;
  int tsec        = 0;
  logic [27:0] sb[$];

  localparam logic [27:0] RESET_VEC = {8'h12, 8'h00, 8'h00, 1'b0, 3'b000};

  clock_12h dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .load_pm   (load_pm),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [24:0] time_vec(input int ts);
    int h24;
    int h12;
    h24 = ts / 3600;
    h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    return {to_bcd(h12), to_bcd((ts / 60) % 60), to_bcd(ts % 60), (h24 >= 12)};
  endfunction

  function automatic bit digits_ok(input logic [7:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
  endfunction

  function automatic bit load_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return digits_ok(h) && digits_ok(m) && digits_ok(s) &&
           (from_bcd(h) >= 1) && (from_bcd(h) <= 12) &&
           (from_bcd(m) <= 59) && (from_bcd(s) <= 59);
  endfunction

  function automatic int load_to_sec(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input logic p);
    int h24;
    h24 = (from_bcd(h) == 12) ? 0 : from_bcd(h);
    if (p) h24 = h24 + 12;
    return h24 * 3600 + from_bcd(m) * 60 + from_bcd(s);
  endfunction

  task automatic check(input logic [27:0] expv, input string tag);
    logic [27:0] obs;
    obs = {hh, mm, ss, pm, min_tick, hour_tick, load_err};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, predict its outcome, then compare after the edge.
  task automatic step(input logic e, input logic l, input logic [7:0] lh,
                      input logic [7:0] lm, input logic [7:0] ls, input logic lp,
                      input string tag);
    logic mt;
    logic ht;
    logic er;
    logic [27:0] expv;
    mt = 1'b0;
    ht = 1'b0;
    er = 1'b0;
    if (l) begin
      if (load_valid(lh, lm, ls)) tsec = load_to_sec(lh, lm, ls, lp);
      else er = 1'b1;
    end else if (e) begin
      tsec = (tsec + 1) % 86400;
      mt = (tsec % 60 == 0);
      ht = (tsec % 3600 == 0);
    end
    sb.push_back({time_vec(tsec), mt, ht, er});
    ena = e;
    load = l;
    load_hh = lh;
    load_mm = lm;
    load_ss = ls;
    load_pm = lp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      expv = sb.pop_front();
      check(expv, tag);
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b0;
    ena = 1'b0;
    load = 1'b0;
    load_hh = 8'h00;
    load_mm = 8'h00;
    load_ss = 8'h00;
    load_pm = 1'b0;

    // Reset state
    #12;
    check(RESET_VEC, "reset_state");
    @(negedge clk);
    reset = 1'b1;
    tsec = 0;
    idle("post_reset_hold");

    // 60 seconds from 12:00:00 AM
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "sec_count");
    idle("after_minute");

    // Full rollover 11:59:59 PM -> 12:00:00 AM
    step(1'b0, 1'b1, 8'h11, 8'h59, 8'h59, 1'b1, "load_1159pm");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "rollover_midnight");

    // 12:59:59 AM -> 01:00:00 AM, pm unchanged
    step(1'b0, 1'b1, 8'h12, 8'h59, 8'h59, 1'b0, "load_1259am");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "hour_12_to_01");

    // 11:59:59 AM -> 12:00:00 PM
    step(1'b0, 1'b1, 8'h11, 8'h59, 8'h59, 1'b0, "load_1159am");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "noon");

    // 09:59:59 -> 10:00:00
    step(1'b0, 1'b1, 8'h09, 8'h59, 8'h59, 1'b1, "load_0959pm");
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "hour_09_to_10");

    // Rejected loads leave time untouched
    step(1'b0, 1'b1, 8'h13, 8'h00, 8'h00, 1'b0, "bad_hh_13");
    idle("err_clears");
    step(1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0, "bad_mm_5a");
    step(1'b0, 1'b1, 8'h00, 8'h10, 8'h10, 1'b0, "bad_hh_00");
    step(1'b0, 1'b1, 8'h05, 8'h10, 8'h60, 1'b0, "bad_ss_60");
    step(1'b1, 1'b1, 8'h1A, 8'h10, 8'h10, 1'b0, "bad_load_eats_ena");
    idle("hold_after_bad");

    // Load with ena together: loaded value exact, no extra second
    step(1'b1, 1'b1, 8'h03, 8'h25, 8'h40, 1'b1, "load_with_ena");
    idle("hold_after_load");

    // Load held high, re-evaluated each cycle
    step(1'b0, 1'b1, 8'h07, 8'h07, 8'h07, 1'b0, "held_load_a");
    step(1'b0, 1'b1, 8'h07, 8'h61, 8'h07, 1'b0, "held_load_bad");
    step(1'b1, 1'b1, 8'h08, 8'h08, 8'h08, 1'b1, "held_load_b");

    // Sparse ticks 1000 cycles apart, crossing 12:59:59 PM -> 01:00:00 PM
    step(1'b0, 1'b1, 8'h12, 8'h59, 8'h58, 1'b1, "load_1259pm");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "sparse_tick");
      for (int j = 0; j < 999; j++) idle("sparse_hold");
    end

    // Asynchronous reset between edges overrides a pending load and tick
    step(1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b1, "load_before_reset");
    #2;
    ena = 1'b1;
    load = 1'b1;
    reset = 1'b0;
    #1;
    check(RESET_VEC, "async_reset");
    @(negedge clk);
    check(RESET_VEC, "reset_held");
    reset = 1'b1;
    tsec = 0;
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "first_tick_after_reset");
    idle("hold_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
